seg_reg_chain: RTL and testbench

//   Parametrised pipeline segment-register chain. Replaces hand-written
//   per-field IF/ID-style registers: DEPTH back-to-back stages, each carrying

---
 rtl/seg_reg_chain.sv | 65 ++++++
 tb/tb_seg_reg_chain.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg_reg_chain.sv
// seg_reg_chain: parametrised pipeline stage registers with bubble/flush control and hazard debug counters
module seg_reg_chain #(
  parameter int DATA_W = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int FLUSH_PRIO = 0,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DEPTH-1:0]        bubble,
  input  logic [DEPTH-1:0]        flush,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [DEPTH-1:0]        stage_valid,
  output logic                    err_drop,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);
  localparam int W = LANES * DATA_W;
  localparam logic PRIO = FLUSH_PRIO != 0;
  logic [W-1:0] data_q [DEPTH];
  logic [W-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] vld_q, src_v, eff_flush, hold, drop;
  assign eff_flush = flush & ({DEPTH{PRIO}} | ~bubble);
  assign hold = bubble & ~eff_flush;
  assign src_d[0] = in_data;
  assign src_v[0] = in_valid;
  assign drop[0] = in_valid & hold[0] & vld_q[0];
  genvar g;
  for (g = 1; g < DEPTH; g++) begin : g_link
    assign src_d[g] = data_q[g-1];
    assign src_v[g] = vld_q[g-1];
    assign drop[g] = vld_q[g-1] & ~hold[g-1] & hold[g];
  end
  assign out_valid = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
  assign stage_valid = vld_q;
  // stage update (clear / hold / load), sticky drop flag and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= {LANES{FLUSH_VAL}};
      vld_q <= '0;
      err_drop <= 1'b0;
      bubble_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (eff_flush[k]) begin
          data_q[k] <= {LANES{FLUSH_VAL}};
          vld_q[k] <= 1'b0;
        end else if (!hold[k]) begin
          data_q[k] <= src_d[k];
          vld_q[k] <= src_v[k];
        end
      end
      err_drop <= err_drop | (|drop);
      bubble_cnt <= bubble_cnt + CNT_W'(bubble[DEPTH-1] & ~&bubble_cnt);
      flush_cnt <= flush_cnt + CNT_W'((|eff_flush) & ~&flush_cnt);
    end
  end
endmodule

// File: tb/tb_seg_reg_chain.sv
// tb_seg_reg_chain: randomized scoreboard bench for three seg_reg_chain configurations
module tb_seg_reg_chain;
  localparam int DW = 16;
  localparam int LN = 2;
  localparam logic [DW-1:0] FV = 16'hA5A5;
  localparam int NCYC = 2000;
  typedef struct {
    logic [2:0]  sv;
    logic        ov;
    logic [31:0] od;
    logic        err;
    int          bc;
    int          fc;
  } exp_t;
  logic clk = 0;
  logic rst;
  logic [2:0] bubble, flush;
  logic in_valid;
  logic [31:0] in_data;
  logic a_ov, b_ov, c_ov, a_err, b_err, c_err;
  logic [31:0] a_od, b_od, c_od;
  logic [2:0] a_sv, b_sv;
  logic [0:0] c_sv;
  logic [3:0] a_bc, a_fc, b_bc, b_fc;
  logic [2:0] c_bc, c_fc;
  int tests = 0;
  int fails = 0;
  exp_t qa[$], qb[$], qc[$];
  logic mv [3][3];
  logic [31:0] md [3][3];
  logic merr [3];
  int mbc [3], mfc [3];
  int mdep [3] = '{3, 3, 1};
  bit mpr [3] = '{0, 1, 0};
  int mcm [3] = '{15, 15, 7};
  always #5 clk = ~clk;
  seg_reg_chain #(.DATA_W(DW), .LANES(LN), .DEPTH(3), .FLUSH_VAL(FV), .FLUSH_PRIO(0), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .bubble(bubble), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_ov), .out_data(a_od), .stage_valid(a_sv), .err_drop(a_err), .bubble_cnt(a_bc), .flush_cnt(a_fc));
  seg_reg_chain #(.DATA_W(DW), .LANES(LN), .DEPTH(3), .FLUSH_VAL(FV), .FLUSH_PRIO(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .bubble(bubble), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(b_ov), .out_data(b_od), .stage_valid(b_sv), .err_drop(b_err), .bubble_cnt(b_bc), .flush_cnt(b_fc));
  seg_reg_chain #(.DATA_W(DW), .LANES(LN), .DEPTH(1), .FLUSH_VAL(FV), .FLUSH_PRIO(0), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .bubble(bubble[0:0]), .flush(flush[0:0]), .in_valid(in_valid), .in_data(in_data),
    .out_valid(c_ov), .out_data(c_od), .stage_valid(c_sv), .err_drop(c_err), .bubble_cnt(c_bc), .flush_cnt(c_fc));
  // reference: a stage array updated from the stage rules, oldest-first so each stage sees the previous contents
  task automatic step(int m);
    bit ef [3];
    bit hd [3];
    bit drop, anyf;
    int n;
    n = mdep[m];
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mv[m][k] = 0;
        md[m][k] = {FV, FV};
      end
      merr[m] = 0;
      mbc[m] = 0;
      mfc[m] = 0;
      return;
    end
    anyf = 0;
    for (int k = 0; k < n; k++) begin
      ef[k] = flush[k] && (mpr[m] || !bubble[k]);
      hd[k] = bubble[k] && !ef[k];
      anyf |= ef[k];
    end
    drop = in_valid && hd[0] && mv[m][0];
    for (int k = 1; k < n; k++) drop |= mv[m][k-1] && !hd[k-1] && hd[k];
    for (int k = n - 1; k >= 0; k--) begin
      if (ef[k]) begin
        mv[m][k] = 0;
        md[m][k] = {FV, FV};
      end else if (!hd[k]) begin
        mv[m][k] = (k == 0) ? in_valid : mv[m][k-1];
        md[m][k] = (k == 0) ? in_data : md[m][k-1];
      end
    end
    merr[m] = merr[m] | drop;
    if (bubble[n-1] && mbc[m] < mcm[m]) mbc[m]++;
    if (anyf && mfc[m] < mcm[m]) mfc[m]++;
  endtask
  function automatic exp_t snap(int m);
    exp_t e;
    e.sv = '0;
    for (int k = 0; k < mdep[m]; k++) e.sv[k] = mv[m][k];
    e.ov = mv[m][mdep[m]-1];
    e.od = md[m][mdep[m]-1];
    e.err = merr[m];
    e.bc = mbc[m];
    e.fc = mfc[m];
    return e;
  endfunction
  task automatic cmp(string nm, longint got, longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic chk(string nm, exp_t e, logic [2:0] sv, logic ov, logic [31:0] od, logic err, int bc, int fc);
    cmp({nm, ".stage_valid"}, sv, e.sv);
    cmp({nm, ".out_valid"}, ov, e.ov);
    cmp({nm, ".out_data"}, od, e.od);
    cmp({nm, ".err_drop"}, err, e.err);
    cmp({nm, ".bubble_cnt"}, bc, e.bc);
    cmp({nm, ".flush_cnt"}, fc, e.fc);
  endtask
  // monitor: one registered snapshot per clock, checked just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("A", e, a_sv, a_ov, a_od, a_err, int'(a_bc), int'(a_fc));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("B", e, b_sv, b_ov, b_od, b_err, int'(b_bc), int'(b_fc));
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        chk("C", e, {2'b0, c_sv}, c_ov, c_od, c_err, int'(c_bc), int'(c_fc));
      end
    end
  end
  // stimulus: directed openers (pass-through, bubble+flush priority, last-stage hold), then random traffic
  initial begin
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      in_data = $urandom;
      if (cyc < 2 || cyc == 30) begin
        rst = 1;
        bubble = 3'b111;
        flush = 3'b000;
        in_valid = 1;
      end else if (cyc < 8) begin
        rst = 0;
        bubble = 3'b000;
        flush = 3'b000;
        in_valid = 1;
        in_data = 32'h100 + 32'(4 * (cyc - 2));
      end else if (cyc < 12) begin
        rst = 0;
        bubble = 3'b111;
        flush = 3'b111;
        in_valid = 0;
      end else if (cyc < 30) begin
        rst = 0;
        bubble = 3'b100;
        flush = 3'b000;
        in_valid = 1;
      end else begin
        rst = ($urandom_range(0, 99) < 2);
        for (int k = 0; k < 3; k++) begin
          bubble[k] = ($urandom_range(0, 99) < 25);
          flush[k] = ($urandom_range(0, 99) < 10);
        end
        in_valid = ($urandom_range(0, 99) < 70);
      end
      for (int m = 0; m < 3; m++) step(m);
      qa.push_back(snap(0));
      qb.push_back(snap(1));
      qc.push_back(snap(2));
      @(negedge clk);
    end
    @(posedge clk);
    #3;
    cmp("scoreboard_drained", qa.size() + qb.size() + qc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
